// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction-fetch controller: state encoding,
// counter widths and a small word-index helper.
package fetch_pkg;

   // State encoding
   localparam logic [2:0] ST_IDLE  = 3'd0;
   localparam logic [2:0] ST_REQ   = 3'd1;
   localparam logic [2:0] ST_WAIT  = 3'd2;
   localparam logic [2:0] ST_VALID = 3'd3;
   localparam logic [2:0] ST_FAULT = 3'd4;

   typedef enum logic [2:0] {
      S_IDLE  = ST_IDLE,
      S_REQ   = ST_REQ,
      S_WAIT  = ST_WAIT,
      S_VALID = ST_VALID,
      S_FAULT = ST_FAULT
   } fetch_state_e;

   // Word counter sized for the largest supported instruction (4 words)
   localparam int MAX_WORDS_PER_INSTR = 4;
   localparam int WORD_CNT_W          = $clog2(MAX_WORDS_PER_INSTR);

   // Wait-timer width sized for the largest supported MFC_TIMEOUT
   localparam int MAX_MFC_TIMEOUT = 255;
   localparam int TMO_W           = $clog2(MAX_MFC_TIMEOUT + 1);

   // True when cnt indexes the final word of a words-long instruction
   function automatic logic is_last_word(input logic [WORD_CNT_W-1:0] cnt,
                                         input int words);
      return int'(cnt) == (words - 1);
   endfunction

endpackage

// File: rtl/fetch_mfc_timer.sv
// Per-word MFC wait timer. Loaded while the controller issues a request,
// counts down during WAIT, and flags expiry on the MFC_TIMEOUT-th WAIT cycle.
// Only instantiated when FETCH_TIMEOUT_EN is defined.
module fetch_mfc_timer
   import fetch_pkg::*;
#(
   parameter int MFC_TIMEOUT = 15
) (
   input  logic clk,
   input  logic rst,
   input  logic load,
   input  logic run,
   output logic expired
);

   logic [TMO_W-1:0] cnt;

   // Count down from MFC_TIMEOUT-1 so that zero marks the last allowed WAIT cycle
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt <= '0;
      end else if (load) begin
         cnt <= TMO_W'(MFC_TIMEOUT - 1);
      end else if (run && (cnt != '0)) begin
         cnt <= cnt - TMO_W'(1);
      end
   end

   assign expired = run && (cnt == '0);

endmodule

// File: rtl/instr_fetch_ctrl.sv
// Multi-word instruction-fetch controller. On start it reads WORDS_PER_INSTR
// consecutive memory words from pc_in using an MFC handshake, assembles them
// into ir_out (word 0 in the LSBs) and offers the result via ir_valid/ir_ready.
// Optional feature macro: FETCH_TIMEOUT_EN adds a per-word MFC watchdog that
// aborts the fetch into FAULT; without it WAIT holds indefinitely and fault
// stays 0.
module instr_fetch_ctrl
   import fetch_pkg::*;
#(
   parameter int ADDR_W          = 16,
   parameter int DATA_W          = 16,
   parameter int WORDS_PER_INSTR = 2,
   parameter int MFC_TIMEOUT     = 15
) (
   input  logic                              clk,
   input  logic                              rst,
   input  logic                              start,
   input  logic [ADDR_W-1:0]                 pc_in,
   output logic                              busy,
   output logic [ADDR_W-1:0]                 mem_addr,
   output logic                              mem_en,
   output logic                              mem_rw,
   input  logic                              mem_mfc,
   input  logic [DATA_W-1:0]                 mem_rdata,
   output logic [WORDS_PER_INSTR*DATA_W-1:0] ir_out,
   output logic                              ir_valid,
   input  logic                              ir_ready,
   output logic [ADDR_W-1:0]                 pc_next,
   output logic                              fault
);

   fetch_state_e          state;
   logic [ADDR_W-1:0]     addr_r;
   logic [WORD_CNT_W-1:0] word_cnt;
   logic                  tmo_load;
   logic                  tmo_run;
   logic                  tmo_expired;

   assign tmo_load = (state == S_REQ);
   assign tmo_run  = (state == S_WAIT);

`ifdef FETCH_TIMEOUT_EN
   fetch_mfc_timer #(
      .MFC_TIMEOUT(MFC_TIMEOUT)
   ) u_mfc_timer (
      .clk    (clk),
      .rst    (rst),
      .load   (tmo_load),
      .run    (tmo_run),
      .expired(tmo_expired)
   );
`else
   localparam int unused_mfc_timeout = MFC_TIMEOUT;
   logic unused_tmo;
   assign unused_tmo  = tmo_load ^ tmo_run;
   assign tmo_expired = 1'b0;
`endif

   // The address register drives the memory port directly, so it is held
   // steady across REQ and every WAIT cycle of a word.
   assign mem_addr = addr_r;

   // Fetch sequencer with registered handshake outputs
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= S_IDLE;
         addr_r   <= '0;
         word_cnt <= '0;
         mem_en   <= 1'b0;
         mem_rw   <= 1'b0;
         busy     <= 1'b0;
         ir_out   <= '0;
         ir_valid <= 1'b0;
         pc_next  <= '0;
         fault    <= 1'b0;
      end else begin
         case (state)
            S_IDLE, S_FAULT: begin
               if (start) begin
                  state    <= S_REQ;
                  addr_r   <= pc_in;
                  word_cnt <= '0;
                  mem_en   <= 1'b1;
                  mem_rw   <= 1'b1;
                  busy     <= 1'b1;
                  fault    <= 1'b0;
               end
            end

            // One cycle of address setup before the memory is expected to answer
            S_REQ: begin
               state <= S_WAIT;
            end

            S_WAIT: begin
               if (mem_mfc) begin
                  for (int i = 0; i < WORDS_PER_INSTR; i++) begin
                     if (int'(word_cnt) == i) begin
                        ir_out[i*DATA_W +: DATA_W] <= mem_rdata;
                     end
                  end
                  if (is_last_word(word_cnt, WORDS_PER_INSTR)) begin
                     state    <= S_VALID;
                     pc_next  <= addr_r + ADDR_W'(1);
                     mem_en   <= 1'b0;
                     mem_rw   <= 1'b0;
                     ir_valid <= 1'b1;
                  end else begin
                     state    <= S_REQ;
                     addr_r   <= addr_r + ADDR_W'(1);
                     word_cnt <= word_cnt + WORD_CNT_W'(1);
                  end
               end else if (tmo_expired) begin
                  // A late MFC in the expiry cycle is taken above, so only a
                  // truly silent memory ends up here.
                  state  <= S_FAULT;
                  mem_en <= 1'b0;
                  mem_rw <= 1'b0;
                  fault  <= 1'b1;
               end
            end

            // Hold the instruction until decode takes it; start is ignored here
            S_VALID: begin
               if (ir_ready) begin
                  state    <= S_IDLE;
                  ir_valid <= 1'b0;
                  busy     <= 1'b0;
               end
            end

            default: begin
               state    <= S_IDLE;
               mem_en   <= 1'b0;
               mem_rw   <= 1'b0;
               busy     <= 1'b0;
               ir_valid <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_instr_fetch_ctrl.sv
// Directed testbench for instr_fetch_ctrl: one 2-word instance and one
// 1-word instance sharing clock and reset. Timeout checks are compiled in
// when FETCH_TIMEOUT_EN is defined.
module tb_instr_fetch_ctrl;

   logic clk;
   logic rst;

   // 2-word instance
   logic        s2_start;
   logic [15:0] s2_pc;
   logic        s2_mfc;
   logic [15:0] s2_rdata;
   logic        s2_ready;
   logic        o2_busy;
   logic [15:0] o2_addr;
   logic        o2_en;
   logic        o2_rw;
   logic [31:0] o2_ir;
   logic        o2_valid;
   logic [15:0] o2_pcn;
   logic        o2_fault;

   // 1-word instance
   logic        s1_start;
   logic [15:0] s1_pc;
   logic        s1_mfc;
   logic [15:0] s1_rdata;
   logic        s1_ready;
   logic        o1_busy;
   logic [15:0] o1_addr;
   logic        o1_en;
   logic        o1_rw;
   logic [15:0] o1_ir;
   logic        o1_valid;
   logic [15:0] o1_pcn;
   logic        o1_fault;

   int total;
   int bad;

   instr_fetch_ctrl #(
      .ADDR_W(16), .DATA_W(16), .WORDS_PER_INSTR(2), .MFC_TIMEOUT(15)
   ) u_dut2 (
      .clk(clk), .rst(rst), .start(s2_start), .pc_in(s2_pc), .busy(o2_busy),
      .mem_addr(o2_addr), .mem_en(o2_en), .mem_rw(o2_rw), .mem_mfc(s2_mfc),
      .mem_rdata(s2_rdata), .ir_out(o2_ir), .ir_valid(o2_valid),
      .ir_ready(s2_ready), .pc_next(o2_pcn), .fault(o2_fault)
   );

   instr_fetch_ctrl #(
      .ADDR_W(16), .DATA_W(16), .WORDS_PER_INSTR(1), .MFC_TIMEOUT(15)
   ) u_dut1 (
      .clk(clk), .rst(rst), .start(s1_start), .pc_in(s1_pc), .busy(o1_busy),
      .mem_addr(o1_addr), .mem_en(o1_en), .mem_rw(o1_rw), .mem_mfc(s1_mfc),
      .mem_rdata(s1_rdata), .ir_out(o1_ir), .ir_valid(o1_valid),
      .ir_ready(s1_ready), .pc_next(o1_pcn), .fault(o1_fault)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
      end
   endtask

   // Two-word fetch with MFC in the first WAIT cycle of each word.
   // Leaves the DUT in VALID unless release is set.
   task automatic run2(input logic [15:0] pc, input logic [15:0] w0,
                       input logic [15:0] w1, input logic [15:0] addr1,
                       input logic release_ir);
      s2_pc    = pc;
      s2_start = 1'b1;
      @(negedge clk);                       // REQ, word 0
      s2_start = 1'b0;
      chk("w2_req0_en",   o2_en, 1);
      chk("w2_req0_rw",   o2_rw, 1);
      chk("w2_req0_addr", o2_addr, pc);
      chk("w2_req0_busy", o2_busy, 1);
      @(negedge clk);                       // WAIT, word 0
      chk("w2_wait0_addr", o2_addr, pc);
      s2_mfc   = 1'b1;
      s2_rdata = w0;
      @(negedge clk);                       // REQ, word 1
      s2_mfc   = 1'b0;
      chk("w2_req1_addr",  o2_addr, addr1);
      chk("w2_req1_valid", o2_valid, 0);
      chk("w2_req1_en",    o2_en, 1);
      @(negedge clk);                       // WAIT, word 1
      s2_mfc   = 1'b1;
      s2_rdata = w1;
      @(negedge clk);                       // VALID
      s2_mfc   = 1'b0;
      chk("w2_valid",  o2_valid, 1);
      chk("w2_ir",     o2_ir, {w1, w0});
      chk("w2_pcnext", o2_pcn, addr1 + 16'd1);
      chk("w2_en_off", o2_en, 0);
      if (release_ir) begin
         s2_ready = 1'b1;
         @(negedge clk);                    // IDLE
         s2_ready = 1'b0;
         chk("w2_rel_valid", o2_valid, 0);
         chk("w2_rel_busy",  o2_busy, 0);
      end
   endtask

   initial begin
      total    = 0;
      bad      = 0;
      rst      = 1'b1;
      s2_start = 1'b0; s2_pc = '0; s2_mfc = 1'b0; s2_rdata = '0; s2_ready = 1'b0;
      s1_start = 1'b0; s1_pc = '0; s1_mfc = 1'b0; s1_rdata = '0; s1_ready = 1'b0;

      // Reset state
      repeat (2) @(negedge clk);
      chk("rst_busy",  o2_busy, 0);
      chk("rst_en",    o2_en, 0);
      chk("rst_rw",    o2_rw, 0);
      chk("rst_valid", o2_valid, 0);
      chk("rst_ir",    o2_ir, 0);
      chk("rst_pcn",   o2_pcn, 0);
      chk("rst_fault", o2_fault, 0);
      chk("rst_addr",  o2_addr, 0);
      chk("rst1_ir",   o1_ir, 0);
      rst = 1'b0;
      @(negedge clk);

      // Single-word fetch, MFC one cycle after WAIT entry
      s1_pc    = 16'h0010;
      s1_start = 1'b1;
      @(negedge clk);                       // REQ
      s1_start = 1'b0;
      chk("w1_req_en",   o1_en, 1);
      chk("w1_req_rw",   o1_rw, 1);
      chk("w1_req_addr", o1_addr, 16'h0010);
      chk("w1_req_busy", o1_busy, 1);
      @(negedge clk);                       // WAIT cycle 1, no MFC
      chk("w1_wait1_valid", o1_valid, 0);
      @(negedge clk);                       // WAIT cycle 2, MFC now
      chk("w1_wait2_valid", o1_valid, 0);
      chk("w1_wait2_en",    o1_en, 1);
      s1_mfc   = 1'b1;
      s1_rdata = 16'hA5A5;
      @(negedge clk);                       // VALID, four cycles after start
      s1_mfc   = 1'b0;
      s1_rdata = 16'h0000;
      chk("w1_valid",  o1_valid, 1);
      chk("w1_ir",     o1_ir, 16'hA5A5);
      chk("w1_pcnext", o1_pcn, 16'h0011);
      chk("w1_en_off", o1_en, 0);
      s1_ready = 1'b1;
      @(negedge clk);
      s1_ready = 1'b0;
      chk("w1_rel_valid", o1_valid, 0);
      chk("w1_rel_busy",  o1_busy, 0);

      // Two-word fetch, left waiting in VALID for the backpressure check
      run2(16'h0100, 16'h1111, 16'h2222, 16'h0101, 1'b0);

      // Backpressure: ready low, stray start and MFC must not disturb anything
      for (int i = 0; i < 10; i++) begin
         if (i == 3) begin
            s2_start = 1'b1;
            s2_pc    = 16'h0500;
         end
         if (i == 5) begin
            s2_mfc   = 1'b1;
            s2_rdata = 16'hDEAD;
         end
         @(negedge clk);
         s2_start = 1'b0;
         s2_mfc   = 1'b0;
         chk("bp_valid", o2_valid, 1);
         chk("bp_ir",    o2_ir, 32'h2222_1111);
         chk("bp_en",    o2_en, 0);
      end
      s2_ready = 1'b1;
      @(negedge clk);
      s2_ready = 1'b0;
      chk("bp_rel_valid", o2_valid, 0);
      chk("bp_rel_busy",  o2_busy, 0);
      @(negedge clk);
      chk("bp_idle_en",   o2_en, 0);
      chk("bp_idle_busy", o2_busy, 0);

      // Address wrap on the second word
      run2(16'hFFFF, 16'hBEEF, 16'hCAFE, 16'h0000, 1'b1);

`ifdef FETCH_TIMEOUT_EN
      // No MFC at all: fault after the 15th WAIT cycle
      s2_pc    = 16'h0200;
      s2_start = 1'b1;
      @(negedge clk);                       // REQ
      s2_start = 1'b0;
      @(negedge clk);                       // WAIT cycle 1
      repeat (14) @(negedge clk);           // WAIT cycle 15
      chk("tmo_pre_fault", o2_fault, 0);
      chk("tmo_pre_en",    o2_en, 1);
      @(negedge clk);                       // FAULT
      chk("tmo_fault",  o2_fault, 1);
      chk("tmo_en",     o2_en, 0);
      chk("tmo_valid",  o2_valid, 0);
      chk("tmo_busy",   o2_busy, 1);
      s2_pc    = 16'h0210;
      s2_start = 1'b1;
      @(negedge clk);                       // relaunch, REQ
      s2_start = 1'b0;
      chk("tmo_relaunch_fault", o2_fault, 0);
      chk("tmo_relaunch_en",    o2_en, 1);
      chk("tmo_relaunch_addr",  o2_addr, 16'h0210);
      @(negedge clk);                       // WAIT cycle 1
      repeat (14) @(negedge clk);           // WAIT cycle 15: MFC beats expiry
      s2_mfc   = 1'b1;
      s2_rdata = 16'h3333;
      @(negedge clk);                       // REQ, word 1
      s2_mfc   = 1'b0;
      chk("tmo_edge_fault", o2_fault, 0);
      chk("tmo_edge_addr",  o2_addr, 16'h0211);
      chk("tmo_edge_en",    o2_en, 1);
      @(negedge clk);                       // WAIT, word 1
      s2_mfc   = 1'b1;
      s2_rdata = 16'h4444;
      @(negedge clk);                       // VALID
      s2_mfc   = 1'b0;
      chk("tmo_edge_valid", o2_valid, 1);
      chk("tmo_edge_ir",    o2_ir, 32'h4444_3333);
      s2_ready = 1'b1;
      @(negedge clk);
      s2_ready = 1'b0;
`endif

      // Asynchronous reset in WAIT clears outputs before the next clock edge
      s2_pc    = 16'h0300;
      s2_start = 1'b1;
      @(negedge clk);                       // REQ
      s2_start = 1'b0;
      @(negedge clk);                       // WAIT
      chk("arst_pre_busy", o2_busy, 1);
      #2 rst = 1'b1;
      #1;
      chk("arst_en",    o2_en, 0);
      chk("arst_busy",  o2_busy, 0);
      chk("arst_valid", o2_valid, 0);
      chk("arst_ir",    o2_ir, 0);
      chk("arst_pcn",   o2_pcn, 0);
      @(negedge clk);
      rst      = 1'b0;
      s2_mfc   = 1'b1;
      s2_rdata = 16'h7777;
      repeat (3) @(negedge clk);
      s2_mfc   = 1'b0;
      chk("arst_late_busy",  o2_busy, 0);
      chk("arst_late_valid", o2_valid, 0);
      chk("arst_late_ir",    o2_ir, 0);
      chk("arst_late_en",    o2_en, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
